// File: rtl/picosoc_iomem_pkg.sv
// Shared types and helpers for the picosoc iomem two-master arbiter.
package picosoc_iomem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } iomem_arb_state_t;

   localparam int IOMEM_REQ_N = 2;

   // On contention pick the requester that was not granted last time.
   function automatic logic rr_pick(input logic [IOMEM_REQ_N-1:0] valid, input logic last);
      if (&valid) begin
         return ~last;
      end
      return valid[1];
   endfunction

endpackage

// File: rtl/picosoc_bus_timeout.sv
// Saturating 16-bit bus watchdog; expired is raised on the last allowed cycle.
module picosoc_bus_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && (count_reg != 16'hFFFF)) begin
         count_reg <= count_reg + 16'd1;
      end
   end

   assign expired = enable && (count_reg == LIMIT);

endmodule

// File: rtl/picosoc_iomem_arbiter.sv
// Round-robin sharing of one iomem slave between two masters, with a watchdog
// that completes a stalled transfer with an error word and logs its address.
module picosoc_iomem_arbiter
   import picosoc_iomem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   input  logic [3:0]  m0_wstrb,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_ready,
   input  logic        m1_valid,
   input  logic [3:0]  m1_wstrb,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_ready,
   output logic        s_valid,
   output logic [3:0]  s_wstrb,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   input  logic        s_ready,
   output logic        err_flag,
   output logic [31:0] err_addr,
   input  logic        err_clear
);

   iomem_arb_state_t state_reg;
   logic             grant_reg;
   logic             last_reg;
   logic [IOMEM_REQ_N-1:0] ready_reg;
   logic [31:0]      rdata_reg [IOMEM_REQ_N];
   logic             err_flag_reg;
   logic [31:0]      err_addr_reg;

   logic [IOMEM_REQ_N-1:0] req_valid;
   logic [3:0]       req_wstrb [IOMEM_REQ_N];
   logic [31:0]      req_addr  [IOMEM_REQ_N];
   logic [31:0]      req_wdata [IOMEM_REQ_N];
   logic             grant_next;
   logic             timer_expired;

   assign req_valid    = {m1_valid, m0_valid};
   assign req_wstrb[0] = m0_wstrb;
   assign req_wstrb[1] = m1_wstrb;
   assign req_addr[0]  = m0_addr;
   assign req_addr[1]  = m1_addr;
   assign req_wdata[0] = m0_wdata;
   assign req_wdata[1] = m1_wdata;

   assign grant_next = rr_pick(req_valid, last_reg);

   picosoc_bus_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_reg != BUSY),
      .enable (state_reg == BUSY),
      .expired(timer_expired)
   );

   // The request is forwarded straight from the granted master so an abandon
   // withdraws it from the slave in the same cycle.
   assign s_valid = (state_reg == BUSY) && req_valid[grant_reg];
   assign s_wstrb = req_wstrb[grant_reg];
   assign s_addr  = req_addr[grant_reg];
   assign s_wdata = req_wdata[grant_reg];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         grant_reg    <= 1'b0;
         last_reg     <= 1'b1;
         ready_reg    <= '0;
         err_flag_reg <= 1'b0;
         err_addr_reg <= '0;
         for (int i = 0; i < IOMEM_REQ_N; i++) begin
            rdata_reg[i] <= '0;
         end
      end else begin
         ready_reg <= '0;
         // A timeout below overrides this clear.
         if (err_clear) begin
            err_flag_reg <= 1'b0;
         end
         case (state_reg)
            IDLE: begin
               if (|req_valid) begin
                  grant_reg <= grant_next;
                  last_reg  <= grant_next;
                  state_reg <= BUSY;
               end
            end
            BUSY: begin
               if (!req_valid[grant_reg]) begin
                  state_reg <= IDLE;
               end else if (s_ready) begin
                  rdata_reg[grant_reg] <= s_rdata;
                  ready_reg[grant_reg] <= 1'b1;
                  state_reg            <= RESP;
               end else if (timer_expired) begin
                  rdata_reg[grant_reg] <= ERR_RDATA;
                  ready_reg[grant_reg] <= 1'b1;
                  err_flag_reg         <= 1'b1;
                  if (!err_flag_reg) begin
                     err_addr_reg <= s_addr;
                  end
                  state_reg <= RESP;
               end
            end
            RESP: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign m0_ready = ready_reg[0];
   assign m1_ready = ready_reg[1];
   assign m0_rdata = rdata_reg[0];
   assign m1_rdata = rdata_reg[1];
   assign err_flag = err_flag_reg;
   assign err_addr = err_addr_reg;

endmodule
